// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared constants and FSM state type for the MNIST layer sequencers
//
// Purpose : layer geometry constants and the conv/pool sequencer state enum.
// Ports   : none (package).

package mnist_pkg;

  localparam int IMG_W   = 28;
  localparam int K       = 5;
  localparam int IntSize = 8;
  localparam int POOL_W  = (IMG_W - K + 1) / 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CAP,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - window walk counters and image address generator
//
// Purpose : holds pooled position (py,px), 2x2 sub-position (dy,dx) and the
//           kernel tap (ky,kx / k); forms the image address of the current tap.
// Ports   : clk, rst_n      clock, async active-low reset
//           clr            zero all counters (pass start)
//           tap_step       advance kernel tap, wraps after the last tap
//           sub_step       advance sub-position in raster order
//           pool_step      advance pooled position, raster order
//           mem_addr       (2py+dy+ky)*IMG_W + (2px+dx+kx)
//           tap_idx        current tap slot k = ky*K+kx
//           sub_first      sub-position is (0,0)
//           last_tap/last_sub/last_pool  end-of-range flags

module conv_addr_gen #(
  parameter int IMG_W  = mnist_pkg::IMG_W,
  parameter int K      = mnist_pkg::K,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              tap_step,
  input  logic              sub_step,
  input  logic              pool_step,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [4:0]        tap_idx,
  output logic              sub_first,
  output logic              last_tap,
  output logic              last_sub,
  output logic              last_pool
);

  localparam int PW = (IMG_W - K + 1) / 2;
  localparam int CW = $clog2(IMG_W);
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  logic [CW-1:0]     py, px;
  logic              dy, dx;
  logic [KW-1:0]     ky, kx;
  logic [4:0]        k;
  logic [ADDR_W-1:0] row, col;

  assign last_tap  = (k == 5'(K*K-1));
  assign last_sub  = dy & dx;
  assign sub_first = ~dy & ~dx;
  assign last_pool = (py == CW'(PW-1)) && (px == CW'(PW-1));
  assign tap_idx   = k;

  assign row      = ADDR_W'({py, 1'b0}) + ADDR_W'(dy) + ADDR_W'(ky);
  assign col      = ADDR_W'({px, 1'b0}) + ADDR_W'(dx) + ADDR_W'(kx);
  assign mem_addr = row * ADDR_W'(IMG_W) + col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      py <= '0; px <= '0; dy <= 1'b0; dx <= 1'b0;
      ky <= '0; kx <= '0; k  <= '0;
    end else if (clr) begin
      py <= '0; px <= '0; dy <= 1'b0; dx <= 1'b0;
      ky <= '0; kx <= '0; k  <= '0;
    end else begin
      if (tap_step) begin
        if (last_tap) begin
          k  <= '0;
          ky <= '0;
          kx <= '0;
        end else begin
          k <= k + 5'd1;
          if (kx == KW'(K-1)) begin
            kx <= '0;
            ky <= ky + KW'(1);
          end else begin
            kx <= kx + KW'(1);
          end
        end
      end
      // (dy,dx) as a 2-bit count gives the order (0,0),(0,1),(1,0),(1,1)
      if (sub_step)
        {dy, dx} <= {dy, dx} + 2'd1;
      if (pool_step) begin
        if (px == CW'(PW-1)) begin
          px <= '0;
          py <= (py == CW'(PW-1)) ? '0 : py + CW'(1);
        end else begin
          px <= px + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_pool_sched.sv
// rtl/conv_pool_sched.sv - conv window sequencer with 2x2 max pooling
//
// Purpose : loads a KxK kernel, fetches each KxK image window from external
//           memory, presents window/kernel to the external dotProduct and
//           streams the 2x2 max of the results over a valid/ready port.
// Ports   : clk, rst_n                 clock, async active-low reset
//           start                      begin a pass (IDLE only)
//           kern_we/kern_idx/kern_data kernel slot write (IDLE only)
//           mem_rd_en/mem_addr/mem_rdata image memory, 1-cycle read latency
//           win_vec/kern_vec           dotProduct operands, slot k at [8k+7:8k]
//           dp_result                  dotProduct result
//           out_valid/out_ready/out_data pooled output stream
//           busy, done                 status

module conv_pool_sched #(
  parameter int IMG_W   = mnist_pkg::IMG_W,
  parameter int K       = mnist_pkg::K,
  parameter int IntSize = mnist_pkg::IntSize,
  parameter int ADDR_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   kern_we,
  input  logic [4:0]             kern_idx,
  input  logic [IntSize-1:0]     kern_data,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [IntSize-1:0]     mem_rdata,
  output logic [K*K*IntSize-1:0] win_vec,
  output logic [K*K*IntSize-1:0] kern_vec,
  input  logic [IntSize-1:0]     dp_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IntSize-1:0]     out_data,
  output logic                   busy,
  output logic                   done
);

  import mnist_pkg::*;

  localparam int NT = K * K;

  state_t             state, state_nxt;
  logic [IntSize-1:0] kern_q [NT];
  logic [IntSize-1:0] win_q  [NT];
  logic [IntSize-1:0] max_q;
  logic               cap_pend;
  logic [4:0]         cap_idx;
  logic               clr, tap_step, sub_step, pool_step;
  logic               sub_first, last_tap, last_sub, last_pool;
  logic [4:0]         tap_idx;

  conv_addr_gen #(
    .IMG_W  (IMG_W),
    .K      (K),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .tap_step  (tap_step),
    .sub_step  (sub_step),
    .pool_step (pool_step),
    .mem_addr  (mem_addr),
    .tap_idx   (tap_idx),
    .sub_first (sub_first),
    .last_tap  (last_tap),
    .last_sub  (last_sub),
    .last_pool (last_pool)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    tap_step  = 1'b0;
    sub_step  = 1'b0;
    pool_step = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          clr       = 1'b1;
        end
      end
      FETCH: begin
        tap_step = 1'b1;
        if (last_tap) state_nxt = WAIT;
      end
      WAIT: state_nxt = CAP;
      CAP: begin
        sub_step  = 1'b1;
        state_nxt = last_sub ? OUT : FETCH;
      end
      OUT: begin
        if (out_ready) begin
          pool_step = 1'b1;
          state_nxt = last_pool ? DONE : FETCH;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_rd_en = (state == FETCH);
  assign out_valid = (state == OUT);
  assign out_data  = out_valid ? max_q : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NT; i++) kern_q[i] <= '0;
    end else if (state == IDLE && kern_we && kern_idx < 5'(NT)) begin
      kern_q[kern_idx] <= kern_data;
    end
  end

  // Read data lags its issue by one cycle, so the tap index travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pend <= 1'b0;
      cap_idx  <= '0;
      for (int i = 0; i < NT; i++) win_q[i] <= '0;
    end else begin
      cap_pend <= mem_rd_en;
      cap_idx  <= tap_idx;
      if (cap_pend) win_q[cap_idx] <= mem_rdata;
    end
  end

  // First sub-position loads, the rest keep the unsigned maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (state == CAP) begin
      if (sub_first || dp_result > max_q) max_q <= dp_result;
    end
  end

  for (genvar g = 0; g < NT; g++) begin : g_pack
    assign win_vec [g*IntSize +: IntSize] = win_q[g];
    assign kern_vec[g*IntSize +: IntSize] = kern_q[g];
  end

endmodule

// File: tb/tb_conv_pool_sched.sv
// tb/tb_conv_pool_sched.sv - scoreboard bench for conv_pool_sched

module tb_conv_pool_sched;

  localparam int IMG_W = 28;
  localparam int K     = 5;
  localparam int AW    = 10;
  localparam int NT    = 25;
  localparam int PW    = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         kern_we = 1'b0;
  logic [4:0]   kern_idx = '0;
  logic [7:0]   kern_data = '0;
  logic         mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]   mem_rdata = '0;
  logic [199:0] win_vec, kern_vec;
  logic [7:0]   dp_result;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_data;
  logic         busy, done;

  conv_pool_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kern_we   (kern_we),
    .kern_idx  (kern_idx),
    .kern_data (kern_data),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .win_vec   (win_vec),
    .kern_vec  (kern_vec),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] img  [1024];
  logic [7:0] kern [NT];

  // external single-port image memory, one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rdata <= img[mem_addr];

  // external dotProduct: unsigned sum of products truncated to 8 bits
  int dp_acc;
  always_comb begin
    dp_acc = 0;
    for (int i = 0; i < NT; i++)
      dp_acc = dp_acc + int'(win_vec[i*8 +: 8]) * int'(kern_vec[i*8 +: 8]);
    dp_result = 8'(dp_acc);
  end

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  logic [7:0] sb_q [$];
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [199:0] pack_kern();
    logic [199:0] v;
    for (int i = 0; i < NT; i++) v[i*8 +: 8] = kern[i];
    return v;
  endfunction

  // reference: every pooled output is the max of four 5x5 correlations mod 256
  task automatic push_expected();
    for (int py = 0; py < PW; py++)
      for (int px = 0; px < PW; px++) begin
        int best;
        best = 0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            int acc;
            acc = 0;
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++)
                acc += int'(img[(2*py+dy+ky)*IMG_W + 2*px+dx+kx]) * int'(kern[ky*K+kx]);
            acc = acc % 256;
            if (acc > best) best = acc;
          end
        sb_q.push_back(8'(best));
      end
  endtask

  // monitor: pops the scoreboard on every accepted output, checks stalls hold
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_extra: actual=%0h expected=none", out_data);
          end else begin
            check("out_data", out_data, sb_q.pop_front());
          end
          n_acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic load_kernel();
    for (int i = 0; i < NT; i++) begin
      @(posedge clk); #1;
      kern_we = 1'b1; kern_idx = 5'(i); kern_data = kern[i];
    end
    @(posedge clk); #1;
    kern_we = 1'b0;
    check("kern_load", kern_vec, pack_kern());
  endtask

  task automatic run_pass(input int hold, input int poke_at, input int sw_slot,
                          input logic [7:0] sw_val, input int exp_done);
    int t0;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1;
    if (sw_slot >= 0) begin
      kern_we = 1'b1; kern_idx = 5'(sw_slot); kern_data = sw_val;
      kern[sw_slot] = sw_val;
    end
    if (hold > 0) out_ready = 1'b0;
    t0 = cyc;
    push_expected();
    @(posedge clk); #1;
    start = 1'b0; kern_we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("first_valid_lat", cyc - t0, 109);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    if (poke_at > 0) begin
      repeat (poke_at) @(posedge clk);
      #1;
      start = 1'b1; kern_we = 1'b1; kern_idx = 5'd0; kern_data = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0; kern_we = 1'b0;
      check("poke_busy", busy, 1);
      check("poke_kern", kern_vec, pack_kern());
    end
    seen = 1'b0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (exp_done > 0) check("done_lat", cyc - t0, exp_done);
    else              check("done_seen", seen, 1);
    check("outputs_drained", sb_q.size(), 0);
    @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 1024; i++) img[i] = '0;
    for (int i = 0; i < NT; i++) kern[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_win", win_vec, 0);
    check("rst_kern", kern_vec, 0);
    rst_n = 1'b1;

    // all-ones image and kernel
    for (int i = 0; i < IMG_W*IMG_W; i++) img[i] = 8'd1;
    for (int i = 0; i < NT; i++) kern[i] = 8'd1;
    load_kernel();
    run_pass(0, 0, -1, 8'h00, 15697);

    // all-16 image: 400 truncates to 144; start/kern_we poked while busy
    for (int i = 0; i < IMG_W*IMG_W; i++) img[i] = 8'd16;
    run_pass(0, 300, -1, 8'h00, 15697);

    // single pixel, single weight, with 50 cycles of backpressure on output 0
    for (int i = 0; i < IMG_W*IMG_W; i++) img[i] = '0;
    img[3*IMG_W + 4] = 8'd9;
    for (int i = 0; i < NT; i++) kern[i] = '0;
    kern[0] = 8'd2;
    load_kernel();
    for (int i = 25; i < 32; i++) begin
      @(posedge clk); #1;
      kern_we = 1'b1; kern_idx = 5'(i); kern_data = 8'hAA;
    end
    @(posedge clk); #1;
    kern_we = 1'b0;
    check("kern_idx_oob", kern_vec, pack_kern());
    run_pass(50, 0, -1, 8'h00, 15747);

    // reset in the FETCH of output 5
    for (int i = 0; i < IMG_W*IMG_W; i++) img[i] = 8'($urandom);
    for (int i = 0; i < NT; i++) kern[i] = 8'($urandom);
    load_kernel();
    base = n_acc;
    @(posedge clk); #1;
    start = 1'b1;
    push_expected();
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000 && n_acc < base + 5; i++) @(negedge clk);
    check("five_outputs", n_acc - base, 5);
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_fetch", mem_rd_en, 1);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    for (int i = 0; i < NT; i++) kern[i] = '0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_rd_en", mem_rd_en, 0);
    check("midrst_win", win_vec, 0);
    check("midrst_kern", kern_vec, pack_kern());
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reload random kernel; last slot written in the same cycle as start
    for (int i = 0; i < IMG_W*IMG_W; i++) img[i] = 8'($urandom);
    for (int i = 0; i < NT; i++) kern[i] = 8'($urandom);
    load_kernel();
    rand_ready = 1'b1;
    run_pass(0, 0, 24, 8'($urandom), -1);
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
